pipeline_hazard_controller: RTL

Central stall/flush/forwarding sequencer for the RV32I 5-stage pipeline (IF/ID/EX/MEM/WB). Drives PC and pipeline-register enables and flushes, and the EX-stage forwarding mux selects. Issues the PC redirect for taken branches and jumps, and holds a redirect that arrives while the data memory is busy. Sits beside the datapath, between the EX branch unit, the data-memory interface and the PC/pipeline registers.

---
 rtl/pipeline_hazard_controller_pkg.sv | 33 +++
 rtl/pipeline_hazard_controller_if.sv | 66 ++++++
 rtl/pipeline_hazard_controller_forwarding_unit.sv | 30 +++
 rtl/pipeline_hazard_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller slice.
//   hz_state_e : sequencer states (BOOT, RUN, MEM_WAIT)
//   fwd_sel_e  : EX operand source select (register file, WB, MEM)
//   REG_ZERO   : architectural x0, never a forwarding or hazard source
//   src_match  : true when a writing stage targets a given source register
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A producing stage can satisfy a read only if it really writes and is
    // not targeting x0 (writes to x0 are architecturally discarded).
    function automatic logic src_match(input logic [4:0] rd,
                                       input logic       wr_en,
                                       input logic [4:0] rs);
        return wr_en && (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller_if
// Bundle between the datapath and the hazard controller.
//   Datapath -> controller : ID/EX source registers and read flags, EX
//     destination and load flag, MEM/WB destinations and write enables,
//     EX redirect pulse and target, data-memory busy.
//   Controller -> datapath : PC and pipeline-register enables, IF/ID and
//     ID/EX flushes, PC redirect valid/target, EX forwarding selects.
// Modports:
//   master : datapath side (drives hazard sources, receives controls)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
    parameter int XLEN = 32
);
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic            ex_mem_read;
    logic [4:0]      mem_rd;
    logic [4:0]      wb_rd;
    logic            mem_reg_write;
    logic            wb_reg_write;
    logic            ex_redirect;
    logic [XLEN-1:0] ex_redirect_target;
    logic            mem_busy;

    logic            pc_en;
    logic            if_id_en;
    logic            id_ex_en;
    logic            ex_mem_en;
    logic            mem_wb_en;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read,
        output mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        output ex_redirect, ex_redirect_target, mem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush,
        input  redirect_valid, redirect_target,
        input  fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read,
        input  mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        input  ex_redirect, ex_redirect_target, mem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush,
        output redirect_valid, redirect_target,
        output fwd_a_sel, fwd_b_sel
    );

endinterface

// File: rtl/pipeline_hazard_controller_forwarding_unit.sv
// ---------------------------------------------------------------------------
// forwarding_unit
// Purely combinational EX operand source select for one operand.
//   ex_rs          : source register of the EX instruction for this operand
//   mem_rd/wb_rd   : destinations of the instructions in MEM/WB
//   mem_reg_write/wb_reg_write : their write enables
//   sel            : FWD_MEM, FWD_WB or FWD_RF
// MEM is younger than WB, so it holds the newer value and wins.
// ---------------------------------------------------------------------------
module forwarding_unit
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output fwd_sel_e   sel
);

    always_comb begin
        sel = FWD_RF;
        if (src_match(mem_rd, mem_reg_write, ex_rs)) begin
            sel = FWD_MEM;
        end else if (src_match(wb_rd, wb_reg_write, ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
// Stall / flush / forwarding sequencer for a 5-stage RV32I pipeline.
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset
//   hz    : pipeline_hazard_controller_if.slave (hazard sources in,
//           enables / flushes / redirect / forwarding selects out)
// Optional build macro HAZARD_PERF_CNT_EN adds 32-bit wrapping counters:
//   stall_cycles    : load-use bubbles inserted
//   flush_events    : redirects applied
//   mem_wait_cycles : cycles frozen on mem_busy
// All outputs are combinational from state, pending redirect and inputs.
// ---------------------------------------------------------------------------
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int BOOT_HOLD = 4,
    parameter int XLEN      = 32
) (
    input  logic clk,
    input  logic rst_n,
    pipeline_hazard_controller_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
    output logic [31:0] mem_wait_cycles
`endif
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_HOLD - 1);

    hz_state_e       state_reg, state_next;
    logic [3:0]      boot_cnt_reg, boot_cnt_next;
    logic            pend_valid_reg, pend_valid_next;
    logic [XLEN-1:0] pend_target_reg, pend_target_next;

    // enable vector order: {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [4:0]      en_vec;
    logic            if_id_flush_c;
    logic            id_ex_flush_c;
    logic            redirect_valid_c;
    logic [XLEN-1:0] redirect_target_c;

    logic            load_use;
    logic            freeze;
    logic            apply_redirect;
    logic            apply_stall;

    fwd_sel_e        fwd_a, fwd_b;

    // ------------------------------------------------------------------
    // Forwarding: independent of sequencer state
    // ------------------------------------------------------------------
    forwarding_unit u_fwd_a (
        .ex_rs         (hz.ex_rs1),
        .mem_rd        (hz.mem_rd),
        .mem_reg_write (hz.mem_reg_write),
        .wb_rd         (hz.wb_rd),
        .wb_reg_write  (hz.wb_reg_write),
        .sel           (fwd_a)
    );

    forwarding_unit u_fwd_b (
        .ex_rs         (hz.ex_rs2),
        .mem_rd        (hz.mem_rd),
        .mem_reg_write (hz.mem_reg_write),
        .wb_rd         (hz.wb_rd),
        .wb_reg_write  (hz.wb_reg_write),
        .sel           (fwd_b)
    );

    // Load in EX whose result is needed by the instruction in ID.
    assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_ZERO) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= BOOT;
            boot_cnt_reg    <= '0;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= '0;
        end else begin
            state_reg       <= state_next;
            boot_cnt_reg    <= boot_cnt_next;
            pend_valid_reg  <= pend_valid_next;
            pend_target_reg <= pend_target_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        boot_cnt_next     = boot_cnt_reg;
        pend_valid_next   = pend_valid_reg;
        pend_target_next  = pend_target_reg;
        en_vec            = 5'b00000;
        if_id_flush_c     = 1'b0;
        id_ex_flush_c     = 1'b0;
        redirect_valid_c  = 1'b0;
        redirect_target_c = '0;
        freeze            = 1'b0;
        apply_redirect    = 1'b0;
        apply_stall       = 1'b0;

        unique case (state_reg)
            BOOT: begin
                // Frozen and flushed; redirects are ignored while booting.
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                if (boot_cnt_reg == BOOT_LAST) begin
                    state_next    = RUN;
                    boot_cnt_next = '0;
                end else begin
                    boot_cnt_next = boot_cnt_reg + 4'd1;
                end
            end

            RUN, MEM_WAIT: begin
                // The cycle mem_busy drops is already a normal RUN cycle,
                // and the cycle it rises is already frozen, so both states
                // share the same combinational rules.
                if (hz.mem_busy) begin
                    freeze     = 1'b1;
                    state_next = MEM_WAIT;
                    if (hz.ex_redirect) begin
                        pend_valid_next  = 1'b1;
                        pend_target_next = hz.ex_redirect_target;
                    end
                end else begin
                    state_next = RUN;
                    if (pend_valid_reg || hz.ex_redirect) begin
                        // A held redirect is older than a fresh pulse.
                        apply_redirect    = 1'b1;
                        redirect_valid_c  = 1'b1;
                        redirect_target_c = pend_valid_reg ? pend_target_reg
                                                           : hz.ex_redirect_target;
                        if_id_flush_c     = 1'b1;
                        id_ex_flush_c     = 1'b1;
                        en_vec            = 5'b11111;
                        pend_valid_next   = 1'b0;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, bubble into EX for one cycle.
                        apply_stall   = 1'b1;
                        en_vec        = 5'b00111;
                        id_ex_flush_c = 1'b1;
                    end else begin
                        en_vec = 5'b11111;
                    end
                end
            end

            default: begin
                state_next    = BOOT;
                boot_cnt_next = '0;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign hz.pc_en           = en_vec[4];
    assign hz.if_id_en        = en_vec[3];
    assign hz.id_ex_en        = en_vec[2];
    assign hz.ex_mem_en       = en_vec[1];
    assign hz.mem_wb_en       = en_vec[0];
    assign hz.if_id_flush     = if_id_flush_c;
    assign hz.id_ex_flush     = id_ex_flush_c;
    assign hz.redirect_valid  = redirect_valid_c;
    assign hz.redirect_target = redirect_target_c;
    // Forwarding is live in every state but held at the register file
    // while reset is asserted.
    assign hz.fwd_a_sel       = rst_n ? fwd_a : FWD_RF;
    assign hz.fwd_b_sel       = rst_n ? fwd_b : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_events_reg;
    logic [31:0] mem_wait_cycles_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_reg    <= '0;
            flush_events_reg    <= '0;
            mem_wait_cycles_reg <= '0;
        end else begin
            if (apply_stall) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (apply_redirect) begin
                flush_events_reg <= flush_events_reg + 32'd1;
            end
            if (freeze) begin
                mem_wait_cycles_reg <= mem_wait_cycles_reg + 32'd1;
            end
        end
    end

    assign stall_cycles    = stall_cycles_reg;
    assign flush_events    = flush_events_reg;
    assign mem_wait_cycles = mem_wait_cycles_reg;
`endif

endmodule
